inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL use the ports below, clock and reset first.
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  reset; synchronous, active-low.
- in_valid  input  1  encode request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  5  operation select (REQ-004).
- in_rd / in_rs1 / in_rs2  input  5 each  register indices.
- in_imm  input  32  byte-offset or immediate value, two's complement.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts word.
- out_inst  output  32  encoded RV32I instruction word.
- out_addr  output  32  instruction-memory byte address for out_inst.
- illegal  output  1  one-cycle pulse: request rejected.
- count  output  16  words emitted, saturating.

REQ-002 The block SHALL have one clock, clk, and a synchronous active-low reset, rstn, with no asynchronous logic.

Function
REQ-003 Transfers SHALL occur only on cycles where valid and ready are both high, on the input side and on the output side.
REQ-004 in_op SHALL use this encoding:
- 0-9: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU
- 10-18: ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU
- 19 LW, 20 SW
- 21-26: BEQ BNE BLT BGE BLTU BGEU
- 27 JAL, 28 JALR, 29 LUI
- 30-31: illegal.
REQ-005 Opcode, funct3 and funct7 SHALL be the standard RV32I values:
- R: 0110011; funct7 0100000 for SUB and SRA, 0000000 otherwise.
- I-ALU: 0010011; SRAI carries 0100000 in bits[31:25].
- LW: 0000011, f3 010.
- SW: 0100011, f3 010.
- B: 1100011.
- JAL: 1101111.
- JALR: 1100111, f3 000.
- LUI: 0110111.
REQ-006 Immediate scattering SHALL follow the RV32I I/S/B/U/J formats. Fields not used by the format (for example rs2 for I-type, rd for S/B) SHALL be ignored.
REQ-007 A request SHALL be illegal, and no word SHALL be emitted for it, in any of these cases:
- in_op is 30 or 31.
- I/LW/SW/JALR: in_imm outside -2048..2047.
- Shift immediates: in_imm[31:5] != 0.
- B-type: in_imm outside -4096..4094, or in_imm[0] = 1.
- JAL: in_imm outside -2^20..2^20-2, or in_imm[0] = 1.
- LUI: in_imm[11:0] != 0; LUI takes imm[31:12] from in_imm[31:12].
REQ-008 illegal SHALL pulse high for exactly one cycle, 2 cycles after the rejected request is accepted. A rejected request SHALL consume its input handshake.
REQ-009 Pipeline: stage S1 registers the request and range checks; stage S2 is the output register.
- Latency from input accept to out_valid SHALL be 2 cycles.
- Throughput SHALL be 1 word per cycle while out_ready is high.
REQ-010 in_ready SHALL be low only when S1 and S2 are both occupied and out_ready is low. No request SHALL be lost or duplicated under any out_ready pattern.
REQ-011 While out_valid is high and out_ready is low, out_inst and out_addr SHALL hold stable.
REQ-012 out_addr SHALL start at 0 and advance by 4 on each output handshake, wrapping from 0xFFFFFFFC to 0. Illegal requests SHALL NOT advance it.
REQ-013 count SHALL increment on each output handshake and saturate at 0xFFFF.
REQ-014 When input accept and output handshake occur in the same cycle, both SHALL take effect.

Reset
REQ-015 While rstn is low at a clock edge:
- in_ready = 0.
- out_valid = 0, illegal = 0.
- out_inst = 0, out_addr = 0, count = 0.
- S1 and S2 contents SHALL be discarded.
REQ-016 in_ready SHALL be 1 in the first cycle after rstn goes high.
REQ-017 Reset asserted mid-stream SHALL drop in-flight requests. No partial word SHALL appear after reset.

Verification
REQ-018 The bench SHALL cover these directed scenarios, with out_ready = 1 unless stated:
- ADD rd=3 rs1=1 rs2=2 -> out_inst 0x002081B3, out_addr 0, 2 cycles after accept; then SRAI rd=1 rs1=2 imm=3 -> 0x40315093 at out_addr 4.
- ADDI rd=1 rs1=0 imm=-1 -> 0xFFF00093; LUI rd=5 imm=0x12345000 -> 0x123452B7; SW rs1=1 rs2=2 imm=4 -> 0x0020A223.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=2048 -> 0x001000EF.
- Illegal requests: ADDI imm=2048, BEQ imm=3, in_op=31 -> illegal pulses 3 times; out_valid stays 0; out_addr and count unchanged.
- Backpressure: out_ready held 0 while 4 requests are offered -> in_ready drops after 2 accepts. out_ready then held 1 -> all 4 words emitted in order, addresses 0,4,8,12, no gaps or duplicates.
- rstn pulsed low with 2 words in flight -> no output after reset; out_addr = 0, count = 0; the next ADD encodes at address 0.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage RV32I instruction word encoder with address and count tracking
module inst_encoder (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        illegal,
    output logic [15:0] count
);

    logic        s1_valid_q, s1_valid_d;
    logic        s1_bad_q, s1_bad_d;
    logic [31:0] s1_inst_q, s1_inst_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  f3;
    logic [31:0] enc_inst;
    logic        enc_bad;
    logic        fits12, fits13, fits21;
    logic        out_fire, in_fire, s1_adv;

    // Signed-range checks: the upper bits must be a pure sign extension.
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13 = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign fits21 = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

    // funct3 lookup shared by the R, I-ALU, load/store and branch groups.
    always_comb begin
        f3 = 3'b000;
        case (in_op)
            5'd2, 5'd11:                f3 = 3'b100;
            5'd3, 5'd12:                f3 = 3'b110;
            5'd4, 5'd13:                f3 = 3'b111;
            5'd5, 5'd14:                f3 = 3'b001;
            5'd6, 5'd7, 5'd15, 5'd16:   f3 = 3'b101;
            5'd8, 5'd17, 5'd19, 5'd20:  f3 = 3'b010;
            5'd9, 5'd18:                f3 = 3'b011;
            5'd22:                      f3 = 3'b001;
            5'd23:                      f3 = 3'b100;
            5'd24:                      f3 = 3'b101;
            5'd25:                      f3 = 3'b110;
            5'd26:                      f3 = 3'b111;
            default:                    f3 = 3'b000;
        endcase
    end

    // Format selection, immediate scattering and legality of the incoming request.
    always_comb begin
        enc_inst = 32'h0;
        enc_bad  = 1'b0;
        case (in_op)
            5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9:
                enc_inst = {7'b0000000, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            5'd1, 5'd7:
                enc_inst = {7'b0100000, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            5'd10, 5'd11, 5'd12, 5'd13, 5'd17, 5'd18: begin
                enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
                enc_bad  = ~fits12;
            end
            5'd14, 5'd15: begin
                enc_inst = {7'b0000000, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
                enc_bad  = |in_imm[31:5];
            end
            5'd16: begin
                enc_inst = {7'b0100000, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
                enc_bad  = |in_imm[31:5];
            end
            5'd19: begin
                enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
                enc_bad  = ~fits12;
            end
            5'd20: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
                enc_bad  = ~fits12;
            end
            5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                enc_bad  = ~fits13;
            end
            5'd27: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
                enc_bad  = ~fits21;
            end
            5'd28: begin
                enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
                enc_bad  = ~fits12;
            end
            5'd29: begin
                enc_inst = {in_imm[31:12], in_rd, 7'b0110111};
                enc_bad  = |in_imm[11:0];
            end
            default: enc_bad = 1'b1;
        endcase
    end

    // Handshakes: a rejected S1 entry never needs S2, so it always drains.
    always_comb begin
        out_fire = s2_valid_q & out_ready;
        s1_adv   = s1_valid_q & (s1_bad_q | ~s2_valid_q | out_ready);
        in_ready = rstn & (~s1_valid_q | s1_adv);
        in_fire  = in_valid & in_ready;
    end

    // Next-state for both pipeline stages, the address tracker and the counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bad_d   = s1_bad_q;
        s1_inst_d  = s1_inst_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        addr_d     = addr_q;
        count_d    = count_q;
        illegal_d  = s1_adv & s1_bad_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_bad_d   = enc_bad;
            s1_inst_d  = enc_inst;
        end
        if (out_fire) begin
            s2_valid_d = 1'b0;
            addr_d     = addr_q + 32'd4;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
        if (s1_adv && !s1_bad_q) begin
            s2_valid_d = 1'b1;
            s2_inst_d  = s1_inst_q;
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_bad_q   <= 1'b0;
            s1_inst_q  <= 32'h0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'h0;
            addr_q     <= 32'h0;
            count_q    <= 16'h0;
            illegal_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bad_q   <= s1_bad_d;
            s1_inst_q  <= s1_inst_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_addr  = addr_q;
    assign illegal   = illegal_q;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rstn, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_inst, out_addr;
    logic [15:0] count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .illegal(illegal), .count(count)
    );

    // Reference encoder: returns {legal, word}, built from integer ranges and shifts.
    function automatic logic [32:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input logic [31:0] imm);
        int          f3r [10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
        int          f3i [9]  = '{0, 4, 6, 7, 1, 5, 5, 2, 3};
        int          f3b [6]  = '{0, 1, 4, 5, 6, 7};
        int          v;
        logic [31:0] u, w;
        logic        ok;
        v  = $signed(imm);
        u  = imm;
        w  = 32'h0;
        ok = 1'b1;
        if (op <= 9) begin
            w = ((op == 1 || op == 7) ? 32'h40000000 : 32'h0) | (rs2 << 20) | (rs1 << 15)
                | (f3r[op] << 12) | (rd << 7) | 32'h33;
        end else if (op <= 18) begin
            if (op >= 14 && op <= 16) begin
                ok = ((u >> 5) == 32'h0);
                w  = ((op == 16) ? 32'h40000000 : 32'h0) | ((u & 32'h1F) << 20) | (rs1 << 15)
                     | (f3i[op-10] << 12) | (rd << 7) | 32'h13;
            end else begin
                ok = (v >= -2048 && v <= 2047);
                w  = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3i[op-10] << 12) | (rd << 7) | 32'h13;
            end
        end else if (op == 19) begin
            ok = (v >= -2048 && v <= 2047);
            w  = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
        end else if (op == 20) begin
            ok = (v >= -2048 && v <= 2047);
            w  = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                 | ((u & 32'h1F) << 7) | 32'h23;
        end else if (op <= 26) begin
            ok = (v >= -4096 && v <= 4094 && (u & 32'h1) == 32'h0);
            w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (f3b[op-21] << 12) | (((u >> 1) & 32'hF) << 8)
                 | (((u >> 11) & 32'h1) << 7) | 32'h63;
        end else if (op == 27) begin
            ok = (v >= -(1 << 20) && v <= (1 << 20) - 2 && (u & 32'h1) == 32'h0);
            w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                 | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                 | (rd << 7) | 32'h6F;
        end else if (op == 28) begin
            ok = (v >= -2048 && v <= 2047);
            w  = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
        end else if (op == 29) begin
            ok = ((u & 32'hFFF) == 32'h0);
            w  = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
        end else begin
            ok = 1'b0;
        end
        return {ok, w};
    endfunction

    task automatic apply_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm);
        int guard = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op[4:0];
        in_rd    = rd[4:0];
        in_rs1   = rs1[4:0];
        in_rs2   = rs2[4:0];
        in_imm   = imm;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op = 5'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0 ||
            out_inst !== 32'h0 || out_addr !== 32'h0 || count !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b ov=%b ill=%b inst=%h addr=%h cnt=%h, required all 0",
                     in_ready, out_valid, illegal, out_inst, out_addr, count);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int          ops  [7] = '{0, 16, 10, 29, 20, 21, 27};
        int          rds  [7] = '{3, 1, 1, 5, 0, 0, 1};
        int          rs1s [7] = '{1, 2, 0, 0, 1, 1, 0};
        int          rs2s [7] = '{2, 0, 0, 0, 2, 2, 0};
        logic [31:0] imms [7] = '{32'h0, 32'h3, 32'hFFFFFFFF, 32'h12345000, 32'h4, 32'h8, 32'd2048};
        logic [31:0] exps [7] = '{32'h002081B3, 32'h40315093, 32'hFFF00093, 32'h123452B7,
                                  32'h0020A223, 32'h00208463, 32'h001000EF};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(ops[i], rds[i], rs1s[i], rs2s[i], imms[i]);
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL latency_early[%0d]: out_valid %b one cycle after accept, required 0",
                         i, out_valid);
            end
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || out_inst !== exps[i] || out_addr !== 32'(i * 4)) begin
                n_bad++;
                $display("FAIL directed[%0d]: ov=%b inst=%h addr=%h, required ov=1 inst=%h addr=%h",
                         i, out_valid, out_inst, out_addr, exps[i], i * 4);
            end
        end
        @(negedge clk);
        n_vec++;
        if (count !== 16'd7 || out_addr !== 32'd28 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL directed_totals: cnt=%0d addr=%h ov=%b, required 7 0000001c 0",
                     count, out_addr, out_valid);
        end
    endtask

    task automatic test_illegal();
        int          ops  [3] = '{10, 21, 31};
        logic [31:0] imms [3] = '{32'd2048, 32'd3, 32'd0};
        logic [15:0] cnt0;
        logic [31:0] addr0;
        cnt0  = count;
        addr0 = out_addr;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 1, 1, 2, imms[i]);
            @(negedge clk);
            n_vec++;
            if (illegal !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_early[%0d]: ill=%b ov=%b, required 0 0", i, illegal, out_valid);
            end
            @(negedge clk);
            n_vec++;
            if (illegal !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_pulse[%0d]: ill=%b ov=%b, required 1 0", i, illegal, out_valid);
            end
            @(negedge clk);
            n_vec++;
            if (illegal !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_width[%0d]: ill=%b ov=%b, required 0 0", i, illegal, out_valid);
            end
        end
        n_vec++;
        if (count !== cnt0 || out_addr !== addr0) begin
            n_bad++;
            $display("FAIL illegal_no_advance: cnt=%0d addr=%h, required %0d %h",
                     count, out_addr, cnt0, addr0);
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        logic [31:0] got_inst [$];
        logic [31:0] got_addr [$];
        logic [31:0] hold_inst, hold_addr;
        logic [32:0] r;
        logic [31:0] e;
        apply_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            in_valid  = (sent < 4);
            in_op     = 5'd0;
            in_rd     = 5'(sent + 1);
            in_rs1    = 5'd1;
            in_rs2    = 5'd2;
            in_imm    = 32'h0;
            out_ready = (cyc >= 6);
            @(negedge clk);
            if (cyc == 2) begin
                hold_inst = out_inst;
                hold_addr = out_addr;
            end
            if (cyc == 5) begin
                r = ref_encode(0, 1, 1, 2, 32'h0);
                e = r[31:0];
                n_vec++;
                if (sent != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== e ||
                    out_addr !== 32'h0) begin
                    n_bad++;
                    $display("FAIL bp_stall: accepts=%0d rdy=%b ov=%b inst=%h addr=%h, required 2 0 1 %h 0",
                             sent, in_ready, out_valid, out_inst, out_addr, e);
                end
                n_vec++;
                if (out_inst !== hold_inst || out_addr !== hold_addr) begin
                    n_bad++;
                    $display("FAIL bp_hold: inst=%h addr=%h, required %h %h",
                             out_inst, out_addr, hold_inst, hold_addr);
                end
            end
            if (out_valid && out_ready) begin
                got_inst.push_back(out_inst);
                got_addr.push_back(out_addr);
            end
            if (in_valid && in_ready) sent++;
        end
        n_vec++;
        if (got_inst.size() != 4 || sent != 4) begin
            n_bad++;
            $display("FAIL bp_word_count: words=%0d accepts=%0d, required 4 4", got_inst.size(), sent);
        end
        for (int i = 0; i < got_inst.size() && i < 4; i++) begin
            r = ref_encode(0, i + 1, 1, 2, 32'h0);
            e = r[31:0];
            n_vec++;
            if (got_inst[i] !== e || got_addr[i] !== 32'(i * 4)) begin
                n_bad++;
                $display("FAIL bp_order[%0d]: inst=%h addr=%h, required %h %h",
                         i, got_inst[i], got_addr[i], e, i * 4);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic seen = 1'b0;
        apply_reset();
        out_ready = 1'b0;
        send(0, 7, 1, 2, 32'h0);
        send(0, 8, 1, 2, 32'h0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen || out_addr !== 32'h0 || count !== 16'h0) begin
            n_bad++;
            $display("FAIL midreset_flush: word_seen=%b addr=%h cnt=%0d, required 0 0 0",
                     seen, out_addr, count);
        end
        send(0, 3, 1, 2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_inst !== 32'h002081B3 || out_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_next: ov=%b inst=%h addr=%h, required 1 002081b3 0",
                     out_valid, out_inst, out_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] word_q [$];
        logic [31:0] bounds [13] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095,
                                     -32'd4096, -32'd4098, 32'h000FFFFE, 32'h00100000,
                                     32'hFFF00000, 32'h12345000, 32'd32};
        int          ill_exp  = 0;
        int          ill_seen = 0;
        int          sent     = 0;
        int          cyc      = 0;
        int          post     = 0;
        logic        drv_done = 1'b0;
        logic [31:0] exp_addr = 32'h0;
        int          exp_count = 0;
        apply_reset();
        fork
            begin
                logic [32:0] r;
                while (sent < 200) begin
                    @(posedge clk);
                    #1;
                    in_op  = 5'($urandom_range(0, 31));
                    in_rd  = 5'($urandom_range(0, 31));
                    in_rs1 = 5'($urandom_range(0, 31));
                    in_rs2 = 5'($urandom_range(0, 31));
                    case ($urandom_range(0, 5))
                        0:       in_imm = 32'($urandom_range(0, 31));
                        1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                        2:       in_imm = $urandom;
                        3:       in_imm = bounds[$urandom_range(0, 12)];
                        4:       in_imm = $urandom & 32'hFFFFF000;
                        default: in_imm = 32'($urandom_range(0, 2097151)) - 32'h00100000;
                    endcase
                    in_valid  = ($urandom_range(0, 9) < 8);
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(negedge clk);
                    if (in_valid && in_ready) begin
                        r = ref_encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm);
                        if (r[32]) word_q.push_back(r[31:0]);
                        else ill_exp++;
                        sent++;
                    end
                end
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                drv_done  = 1'b1;
            end
            begin
                while (!(drv_done && word_q.size() == 0 && post >= 8) && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (drv_done) post++;
                    if (!in_ready) begin
                        n_vec++;
                        if (!(out_valid && !out_ready)) begin
                            n_bad++;
                            $display("FAIL rand_ready: in_ready low with ov=%b or=%b, required ov=1 or=0",
                                     out_valid, out_ready);
                        end
                    end
                    if (out_valid && out_ready) begin
                        n_vec++;
                        if (word_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL rand_extra: unexpected word %h at %h", out_inst, out_addr);
                        end else if (out_inst !== word_q[0] || out_addr !== exp_addr) begin
                            n_bad++;
                            $display("FAIL rand_word: inst=%h addr=%h, required %h %h",
                                     out_inst, out_addr, word_q[0], exp_addr);
                        end
                        if (word_q.size() != 0) void'(word_q.pop_front());
                        exp_addr  = exp_addr + 32'd4;
                        exp_count = exp_count + 1;
                    end
                    if (illegal) ill_seen++;
                end
            end
        join
        n_vec++;
        if (cyc >= 5000 || word_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_drain: cycles=%0d pending=%0d, required <5000 0", cyc, word_q.size());
        end
        n_vec++;
        if (ill_seen != ill_exp) begin
            n_bad++;
            $display("FAIL rand_illegal: pulses=%0d, required %0d", ill_seen, ill_exp);
        end
        n_vec++;
        if (count !== 16'(exp_count) || out_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL rand_totals: cnt=%0d addr=%h, required %0d %h",
                     count, out_addr, exp_count, exp_addr);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
